// File: rtl/fsrc_seq_pkg.sv
// Shared types and constants for the FSRC trigger sequencer and its receive-side checker.
package fsrc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } fsrc_rx_state_t;

    // Sequencer stretches each trigger to this many clk cycles
    localparam int TRIG_PULSE_WIDTH = 4;

endpackage

// File: rtl/fsrc_trig_lane_rx.sv
// One trigger lane: edge detect, high-time measurement, first-edge timestamp and sticky seen/err flags.
module fsrc_trig_lane_rx
    import fsrc_seq_pkg::*;
#(
    parameter int COUNTER_WIDTH = 4,
    parameter int PULSE_MIN     = TRIG_PULSE_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     active,
    input  logic                     trig_in,
    input  logic [COUNTER_WIDTH-1:0] count,
    input  logic [COUNTER_WIDTH-1:0] expected,
    input  logic                     force_err,
    output logic                     first_rise,
    output logic                     seen_nxt,
    output logic                     err_nxt,
    output logic                     seen,
    output logic                     err,
    output logic [COUNTER_WIDTH-1:0] stamp
);

    localparam int HW = $clog2(PULSE_MIN + 1);
    localparam logic [HW-1:0] PMIN = HW'(PULSE_MIN);

    logic          trig_d;
    logic [HW-1:0] high_cnt;
    logic          rise;
    logic          fall;
    logic          dup;
    logic          short_pulse;
    logic          mis_timed;

    // seen_nxt/err_nxt include this cycle's events so the top can judge completion on them
    always_comb begin
        rise        = trig_in & ~trig_d;
        fall        = ~trig_in & trig_d;
        first_rise  = active & rise & ~seen;
        dup         = active & rise & seen;
        short_pulse = active & fall & (high_cnt < PMIN);
        mis_timed   = first_rise & (count != expected);
        seen_nxt    = seen | first_rise;
        err_nxt     = err | dup | short_pulse | mis_timed;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trig_d   <= 1'b0;
            high_cnt <= '0;
            seen     <= 1'b0;
            err      <= 1'b0;
            stamp    <= '0;
        end else begin
            trig_d <= trig_in;
            if (trig_in) begin
                if (high_cnt < PMIN) high_cnt <= high_cnt + 1'b1;
            end else begin
                high_cnt <= '0;
            end
            if (clear) begin
                seen  <= 1'b0;
                err   <= 1'b0;
                stamp <= '0;
            end else begin
                seen <= seen_nxt;
                err  <= err_nxt | force_err;
                if (first_rise) stamp <= count;
            end
        end
    end

endmodule

// File: rtl/fsrc_rx_trig_checker.sv
// Receive-side FSRC trigger checker: arms a window, timestamps lane triggers against sysref and applies the shadow control word.
//   state    | meaning
//   ST_IDLE  | no window since reset
//   ST_ARMED | window open, counting sysref and collecting triggers
//   ST_DONE  | data_start seen with every lane good
//   ST_ERROR | data_start with a bad/missing lane, or sysref timeout
module fsrc_rx_trig_checker
    import fsrc_seq_pkg::*;
#(
    parameter int CTRL_WIDTH    = 40,
    parameter int COUNTER_WIDTH = 4,
    parameter int NUM_TRIG      = 4,
    parameter int PULSE_MIN     = TRIG_PULSE_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    sysref_int,
    input  logic                                    arm,
    input  logic [NUM_TRIG-1:0]                     trig_in,
    input  logic                                    data_start_in,
    input  logic [CTRL_WIDTH-1:0]                   next_ctrl_value,
    input  logic [NUM_TRIG-1:0][COUNTER_WIDTH-1:0]  expected_trig_cnt,
    input  logic [COUNTER_WIDTH-1:0]                timeout_cnt,
    output logic [CTRL_WIDTH-1:0]                   ctrl_active,
    output logic                                    ctrl_update,
    output logic [NUM_TRIG-1:0]                     trig_seen,
    output logic [NUM_TRIG-1:0][COUNTER_WIDTH-1:0]  trig_stamp,
    output logic [NUM_TRIG-1:0]                     trig_err,
    output logic                                    timeout_err,
    output logic                                    busy,
    output logic                                    done
);

    fsrc_rx_state_t             state, state_nxt;
    logic [COUNTER_WIDTH-1:0]   count, count_inc;
    logic [CTRL_WIDTH-1:0]      shadow;
    logic                       data_start_d;
    logic                       ds_rise;
    logic                       lane_active;
    logic                       done_set;
    logic                       timeout_set;
    logic                       ds_fail;
    logic [NUM_TRIG-1:0]        first_rise;
    logic [NUM_TRIG-1:0]        seen_nxt;
    logic [NUM_TRIG-1:0]        err_nxt;
    logic [NUM_TRIG-1:0]        force_err;

    assign ds_rise     = data_start_in & ~data_start_d;
    assign lane_active = (state == ST_ARMED) & ~arm;
    assign count_inc   = (count == '1) ? count : count + 1'b1;
    assign force_err   = {NUM_TRIG{ds_fail}} & ~seen_nxt;
    assign busy        = (state == ST_ARMED);

    for (genvar i = 0; i < NUM_TRIG; i++) begin : g_lane
        fsrc_trig_lane_rx #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .PULSE_MIN     (PULSE_MIN)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .clear      (arm),
            .active     (lane_active),
            .trig_in    (trig_in[i]),
            .count      (count),
            .expected   (expected_trig_cnt[i]),
            .force_err  (force_err[i]),
            .first_rise (first_rise[i]),
            .seen_nxt   (seen_nxt[i]),
            .err_nxt    (err_nxt[i]),
            .seen       (trig_seen[i]),
            .err        (trig_err[i]),
            .stamp      (trig_stamp[i])
        );
    end

    // Timeout compares the post-strobe count, so timeout_cnt strobes end the window
    always_comb begin
        state_nxt   = state;
        done_set    = 1'b0;
        timeout_set = 1'b0;
        ds_fail     = 1'b0;
        if (arm) begin
            state_nxt = ST_ARMED;
        end else if (state == ST_ARMED) begin
            if (ds_rise) begin
                if ((&seen_nxt) && !(|err_nxt)) begin
                    state_nxt = ST_DONE;
                    done_set  = 1'b1;
                end else begin
                    state_nxt = ST_ERROR;
                    ds_fail   = 1'b1;
                end
            end else if (sysref_int && (count_inc == timeout_cnt)) begin
                state_nxt   = ST_ERROR;
                timeout_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            count        <= '0;
            shadow       <= '0;
            ctrl_active  <= '0;
            ctrl_update  <= 1'b0;
            timeout_err  <= 1'b0;
            done         <= 1'b0;
            data_start_d <= 1'b0;
        end else begin
            state        <= state_nxt;
            done         <= done_set;
            data_start_d <= data_start_in;
            ctrl_update  <= first_rise[0];
            if (first_rise[0]) ctrl_active <= shadow;
            if (arm) begin
                shadow      <= next_ctrl_value;
                count       <= '0;
                timeout_err <= 1'b0;
            end else begin
                if (timeout_set) timeout_err <= 1'b1;
                if ((state == ST_ARMED) && sysref_int) count <= count_inc;
            end
        end
    end

endmodule

// File: doc/fsrc_rx_trig_checker.md
Name: fsrc_rx_trig_checker

Overview:
- Far end of the TX FSRC sequencer trigger interface. It receives the stretched per-lane trigger pulses and the data_start_0 pulse.
- Timestamps every trigger rising edge against a sysref count started at arm.
- Applies a shadowed control word on lane-0 trigger and flags mis-timed, duplicate, short or missing triggers.
- Sits in the FSRC datapath clock domain, next to the FSRC core it controls; its status goes to the regmap.

Parameters:
- CTRL_WIDTH, 40, width of control word applied to FSRC core
- COUNTER_WIDTH, 4, sysref counter and timestamp width
- NUM_TRIG, 4, number of trigger lanes
- PULSE_MIN, 4, minimum legal trigger high time in clk cycles

Ports:
- clk  in  1  datapath clock
- reset  in  1  synchronous, active-high
- sysref_int  in  1  single-cycle sysref strobe, clk domain
- arm  in  1  single-cycle pulse; latches shadow ctrl and starts a check window
- trig_in  in  NUM_TRIG  stretched trigger pulses from sequencer
- data_start_in  in  1  end-of-sequence marker (data_start_0)
- next_ctrl_value  in  CTRL_WIDTH  sampled at arm
- expected_trig_cnt  in  NUM_TRIG x COUNTER_WIDTH  expected sysref count per lane
- timeout_cnt  in  COUNTER_WIDTH  sysref count at which the window aborts
- ctrl_active  out  CTRL_WIDTH  control word driven to FSRC core
- ctrl_update  out  1  one-cycle pulse when ctrl_active changes
- trig_seen  out  NUM_TRIG  sticky, lane edge received this window
- trig_stamp  out  NUM_TRIG x COUNTER_WIDTH  count at first edge per lane
- trig_err  out  NUM_TRIG  sticky per-lane error
- timeout_err  out  1  sticky
- busy  out  1  high in ARMED
- done  out  1  one-cycle pulse on successful completion

Behaviour:
- Reset values:
  - All outputs 0, including ctrl_active.
  - Internal counters 0, shadow 0, state IDLE, trig_in_d 0.
- Edge detection:
  - rise[i] = trig_in[i] & ~trig_in_d[i].
  - trig_in_d is registered every cycle, in all states.
- Sysref counter:
  - Cleared on arm.
  - While ARMED, increments on sysref_int and saturates at all-ones (no wrap).
- States: IDLE, ARMED, DONE, ERROR.
- Transitions:
  - Any state, arm=1 -> ARMED. Same cycle:
    - shadow <= next_ctrl_value
    - trig_seen, trig_err, trig_stamp, timeout_err cleared
    - count <= 0
  - ARMED, data_start_in rising edge:
    - all trig_seen set and no trig_err -> DONE, done pulses 1 cycle.
    - otherwise -> ERROR; unseen lanes get trig_err set.
  - ARMED, count == timeout_cnt at a sysref_int -> ERROR, timeout_err=1.
  - DONE/ERROR hold until next arm. Status stays readable.
- Per lane in ARMED:
  - First rise at cycle N: trig_stamp = count value before any same-cycle increment; trig_seen=1 at N+1.
  - trig_err=1 if the stamp differs from expected_trig_cnt[i].
  - Second rise in the same window: trig_err=1, stamp keeps first value.
  - High-time counter runs while trig_in[i]=1. A fall with high time < PULSE_MIN sets trig_err.
  - A pulse still high on leaving ARMED is not width-checked.
- Ctrl apply:
  - First rise on lane 0 in ARMED at cycle N -> ctrl_active <= shadow and ctrl_update=1 at N+1.
  - This happens even if the lane-0 stamp is mis-timed.
  - A duplicate lane-0 rise does not re-apply.
- Edges outside ARMED are ignored (no status change).
- Simultaneous events in ARMED, priority: arm > data_start_in > timeout.
  - Trigger edges in the same cycle as data_start_in are recorded before the completion check.
- Reset mid-window returns to IDLE with all outputs cleared. ctrl_active returns to 0.

Decomposition:
- Shared package fsrc_seq_pkg:
  - state enum fsrc_rx_state_t.
  - TRIG_PULSE_WIDTH=4, shared with the sequencer as the PULSE_MIN default.
- Sub-module fsrc_trig_lane_rx, one instance per lane, generated.
  - Contains: edge detect, high-time counter, stamp, seen/err flags.
- Top level holds the FSM, sysref counter, shadow/ctrl registers and completion logic.

Test Plan:
- Nominal:
  - Stimulus: arm, next_ctrl=0x12_3456_789A, expected {1,2,3,4}; 4-cycle pulses at counts 1..4; data_start at count 6.
  - Response: trig_seen=4'hF, stamps {1,2,3,4}, trig_err=0, done pulse, ctrl_active=0x12_3456_789A one cycle after the lane-0 edge.
- Mis-timed lane:
  - Stimulus: lane 2 fires at count 5, expected 3.
  - Response: trig_err=4'b0100, stamp[2]=5, state ERROR at data_start, no done.
- Short and duplicate:
  - Stimulus: lane 1 high for 2 cycles; lane 3 fires twice.
  - Response: trig_err=4'b1010, stamp[3] equals the first edge's count.
- Timeout:
  - Stimulus: timeout_cnt=8, no data_start, 8 sysref strobes.
  - Response: timeout_err=1, ERROR, busy=0.
- Missing lane:
  - Stimulus: lanes 0-2 correct, lane 3 absent, data_start.
  - Response: trig_err=4'b1000, ERROR.
- Re-arm and reset:
  - Stimulus: arm mid-window, status cleared, count=0, new shadow used; then reset while ARMED.
  - Response: IDLE, ctrl_active=0, all flags 0.
